// File: rtl/fetch_prefetch.sv
// RV32I fetch stage: request/response imem interface, in-flight address queue and
// DEPTH-entry prefetch buffer. Define FETCH_PERF_CNT_EN to add performance counters.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_out,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] alu_out,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stall_cycles,
`endif
    output logic            misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [AW-1:0]   iq_wr_reg, iq_wr_next, iq_rd_reg, iq_rd_next;
    logic [AW-1:0]   buf_head_reg, buf_head_next, buf_tail_reg, buf_tail_next;
    logic            misalign_reg, misalign_next;

    logic [XLEN-1:0] inflight_mem [DEPTH];
    logic [XLEN-1:0] buf_pc_mem   [DEPTH];
    logic [31:0]     buf_instr_mem[DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] target_aligned;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            rsp_keep;
    logic            buf_push;
    logic            buf_pop;
    logic            iq_push;

    assign redirect       = branch_out | jal | jalr;
    assign target         = jalr ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
    assign target_aligned = target & ~XLEN'(3);

    // Credit counts every outstanding request, including ones that will be dropped.
    assign in_use         = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign imem_req_valid = rst & (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_keep = imem_rsp_valid & (drop_cnt_reg == '0);
    assign buf_push = rsp_keep & ~redirect;
    assign buf_pop  = out_valid & out_ready & ~redirect;
    assign iq_push  = req_fire & ~redirect;

    assign out_valid = (count_reg != '0);
    assign out_pc    = out_valid ? buf_pc_mem[buf_head_reg] : '0;
    assign out_instr = out_valid ? buf_instr_mem[buf_head_reg] : '0;
    assign misalign  = misalign_reg;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        count_next       = count_reg;
        drop_cnt_next    = drop_cnt_reg;
        iq_wr_next       = iq_wr_reg;
        iq_rd_next       = iq_rd_reg;
        buf_head_next    = buf_head_reg;
        buf_tail_next    = buf_tail_reg;
        misalign_next    = 1'b0;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect) begin
            // Everything already requested but not yet returned must be discarded.
            fetch_pc_next = target_aligned;
            misalign_next = target[1];
            count_next    = '0;
            drop_cnt_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
            iq_wr_next    = '0;
            iq_rd_next    = '0;
            buf_head_next = '0;
            buf_tail_next = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
            end
            if (imem_rsp_valid && drop_cnt_reg != '0) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
            iq_wr_next    = iq_wr_reg + AW'(iq_push);
            iq_rd_next    = iq_rd_reg + AW'(buf_push);
            buf_tail_next = buf_tail_reg + AW'(buf_push);
            buf_head_next = buf_head_reg + AW'(buf_pop);
            count_next    = count_reg + CW'(buf_push) - CW'(buf_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg    <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            iq_wr_reg       <= '0;
            iq_rd_reg       <= '0;
            buf_head_reg    <= '0;
            buf_tail_reg    <= '0;
            misalign_reg    <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            iq_wr_reg       <= iq_wr_next;
            iq_rd_reg       <= iq_rd_next;
            buf_head_reg    <= buf_head_next;
            buf_tail_reg    <= buf_tail_next;
            misalign_reg    <= misalign_next;
        end
    end

    // Storage needs no reset: occupancy counters qualify every read.
    always_ff @(posedge clk) begin
        if (iq_push) begin
            inflight_mem[iq_wr_reg] <= fetch_pc_reg;
        end
        if (buf_push) begin
            buf_pc_mem[buf_tail_reg]    <= inflight_mem[iq_rd_reg];
            buf_instr_mem[buf_tail_reg] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects_reg;
    logic [31:0] perf_stall_cycles_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_redirects_reg    <= '0;
            perf_stall_cycles_reg <= '0;
        end else begin
            if (redirect) begin
                perf_redirects_reg <= perf_redirects_reg + 32'd1;
            end
            if (out_ready && !out_valid) begin
                perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_redirects    = perf_redirects_reg;
    assign perf_stall_cycles = perf_stall_cycles_reg;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: in-order imem model with programmable latency,
// a redirect vector table and hand-written multi-cycle sequences.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_out = 1'b0, jal = 1'b0, jalr = 1'b0;
    logic [31:0] alu_out = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
`endif

    fetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_out     (branch_out),
        .jal            (jal),
        .jalr           (jalr),
        .alu_out        (alu_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_redirects   (perf_redirects),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // In-order memory: a request accepted in cycle k is answered in cycle k+lat.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    logic        s_hs, s_rsp;
    logic [31:0] s_addr;

    always @(posedge clk) cyc = cyc + 1;

    always begin
        @(negedge clk);
        s_hs   = rst && imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        s_rsp  = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (!rst) begin
            mq.delete();
        end else begin
            if (s_rsp && mq.size() > 0) void'(mq.pop_front());
            if (s_hs) mq.push_back('{s_addr, cyc - 1 + lat});
        end
        if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        branch_out = 1'b0; jal = 1'b0; jalr = 1'b0; alu_out = '0;
        repeat (2) tick();
    endtask

    task automatic wait_valid(input int limit, output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found  = 1'b1;
                waited = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic        br;
        logic        jl;
        logic        jr;
        logic [31:0] alu;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs_cnt;
        int   waited;
        bit   found;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h0000_0200, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h0000_0200, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0306, 32'h0000_0304, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0004, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0010, 1'b1};

        // Reset state and streaming with 1-cycle memory latency.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        sample();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("stream_req_valid", 32'(imem_req_valid), 32'd1);
            chk("stream_req_addr", imem_req_addr, 32'(4 * k));
            if (k >= 2) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_out_pc", out_pc, 32'(4 * (k - 2)));
                chk("stream_out_instr", out_instr, mem_word(32'(4 * (k - 2))));
            end else begin
                chk("stream_early_valid", 32'(out_valid), 32'd0);
            end
            tick();
        end

        // Decode stalled: credit stops requests at DEPTH, then drains one per cycle.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (imem_req_valid && imem_req_ready) hs_cnt++;
            tick();
        end
        chk("full_request_count", 32'(hs_cnt), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (k == 0) chk("full_req_valid", 32'(imem_req_valid), 32'd0);
            if (k == 1) begin
                chk("refill_req_valid", 32'(imem_req_valid), 32'd1);
                chk("refill_req_addr", imem_req_addr, 32'h10);
            end
            chk("drain_out_valid", 32'(out_valid), 32'd1);
            chk("drain_out_pc", out_pc, 32'(4 * k));
            chk("drain_out_instr", out_instr, mem_word(32'(4 * k)));
            tick();
        end

        // 3-cycle latency, jal while two requests are in flight.
        do_reset();
        lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0; jal = 1'b1; alu_out = 32'h100;
        sample();
        chk("lat3_pre_valid", 32'(out_valid), 32'd0);
        tick();
        jal = 1'b0; imem_req_ready = 1'b1;
        wait_valid(20, waited, found);
        chk("lat3_found", 32'(found), 32'd1);
        chk("lat3_wait", 32'(waited), 32'd4);
        chk("lat3_first_pc", out_pc, 32'h100);
        chk("lat3_first_instr", out_instr, mem_word(32'h100));
        tick();
        sample();
        chk("lat3_second_pc", out_pc, 32'h104);

        // Redirect vector table with 1-cycle latency streaming.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            branch_out = vecs[i].br; jal = vecs[i].jl; jalr = vecs[i].jr; alu_out = vecs[i].alu;
            tick();
            branch_out = 1'b0; jal = 1'b0; jalr = 1'b0;
            sample();
            chk($sformatf("vec%0d_addr", i), imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_flushed", i), 32'(out_valid), 32'd0);
            tick();
            sample();
            chk($sformatf("vec%0d_mis_clear", i), 32'(misalign), 32'd0);
            chk($sformatf("vec%0d_next_addr", i), imem_req_addr, vecs[i].exp_addr + 32'd4);
            tick();
        end

        // Redirect coinciding with a response and a pop.
        repeat (4) tick();
        branch_out = 1'b1; alu_out = 32'h400;
        sample();
        chk("coinc_pop_valid", 32'(out_valid), 32'd1);
        chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        branch_out = 1'b0;
        sample();
        chk("coinc_empty1", 32'(out_valid), 32'd0);
        chk("coinc_addr", imem_req_addr, 32'h400);
        tick();
        sample();
        chk("coinc_empty2", 32'(out_valid), 32'd0);
        tick();
        sample();
        chk("coinc_valid", 32'(out_valid), 32'd1);
        chk("coinc_pc", out_pc, 32'h400);
        chk("coinc_instr", out_instr, mem_word(32'h400));

        // Back-to-back redirects: the second target wins.
        tick();
        jal = 1'b1; alu_out = 32'h500;
        tick();
        alu_out = 32'h600;
        tick();
        jal = 1'b0;
        sample();
        chk("b2b_addr", imem_req_addr, 32'h600);
        chk("b2b_flushed", 32'(out_valid), 32'd0);
        tick();
        wait_valid(20, waited, found);
        chk("b2b_found", 32'(found), 32'd1);
        chk("b2b_pc", out_pc, 32'h600);

        // Asynchronous reset with three buffered entries.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        imem_req_ready = 1'b0;
        tick();
        sample();
        chk("buf3_valid", 32'(out_valid), 32'd1);
        chk("buf3_pc", out_pc, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_pc", out_pc, 32'h0);
        tick();
        tick();
        rst = 1'b1; imem_req_ready = 1'b1;
        sample();
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_req_addr, 32'h0);
        chk("restart_out_valid", 32'(out_valid), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        sample();
        chk("perf_redirects_rst", perf_redirects, 32'd0);
        tick();
        jal = 1'b1; alu_out = 32'h40;
        tick();
        jal = 1'b0;
        tick();
        branch_out = 1'b1; alu_out = 32'h80;
        tick();
        branch_out = 1'b0;
        sample();
        chk("perf_redirects_two", perf_redirects, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised next-generation RV32I fetch stage.
- Replaces the single-register PC with a request/response instruction-memory interface, an in-flight address queue and a DEPTH-entry prefetch buffer feeding decode through a valid/ready handshake.
- Redirects from execute (branch taken, jal, jalr) flush all prefetched and in-flight instructions.
- Sits between the PC-redirect outputs of execute and the decode stage.

Parameters:
XLEN, 32, address/PC width in bits
DEPTH, 4, prefetch-buffer entries; also the maximum of outstanding requests plus buffered entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
branch_out  in  1  conditional branch taken (execute)
jal  in  1  jal in execute
jalr  in  1  jalr in execute
alu_out  in  XLEN  redirect target from ALU
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid; responses arrive in order, no backpressure
imem_rsp_data  in  32  instruction word
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_pc  out  XLEN  PC of head instruction
out_instr  out  32  head instruction
misalign  out  1  one-cycle pulse: redirect target not 4-byte aligned

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC; buffer and in-flight queue empty; outstanding=0; drop_cnt=0; out_valid=0; out_pc=0; out_instr=0; misalign=0; imem_req_valid=0 while rst=0.
- redirect = branch_out | jal | jalr.
- target = jalr ? {alu_out[XLEN-1:1],1'b0} : alu_out.
- misalign is registered: it is 1 the cycle after a redirect with target[1]=1. Fetch continues from {target[XLEN-1:2],2'b00}.
- Credit: imem_req_valid = (outstanding + count) < DEPTH. It does not depend combinationally on redirect. imem_req_addr = fetch_pc.
- Request handshake (valid & ready, no redirect): fetch_pc += 4, wrapping mod 2^XLEN. The address is pushed into the in-flight queue and outstanding increments.
- Response with drop_cnt=0: pop the in-flight queue and write {pc, data} into the buffer. out_valid rises the cycle after imem_rsp_valid (1-cycle registered latency).
- Response with drop_cnt>0: the response is discarded and drop_cnt decrements. outstanding decrements on every response.
- Output: out_pc/out_instr are the buffer head. A pop occurs on out_valid & out_ready. Simultaneous push and pop is legal at any occupancy, including full.
- Redirect cycle has priority over everything, effective next edge:
  - buffer and in-flight queue cleared; out_valid=0 next cycle;
  - fetch_pc = aligned target;
  - drop_cnt = outstanding + (request handshake this cycle) - (response this cycle);
  - any pop or push in that cycle is discarded.
- Redirect while drop_cnt>0: the new drop_cnt is computed by the same formula, and is then equal to the existing in-flight total.
- New requests may issue while drop_cnt>0, provided credit is available.
- Back-to-back redirects: the last one wins; each one flushes.
- Full: credit prevents response overflow. Responses never arrive with no outstanding request; this is the memory's contract.
- The instruction memory shares rst. Mid-operation reset discards all in-flight state.
- Counter widths: outstanding, count and drop_cnt are $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two output ports:
  - perf_redirects (32 bits): increments on each redirect cycle.
  - perf_stall_cycles (32 bits): increments on each cycle with out_ready=1 and out_valid=0.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset release, imem ready=1, 1-cycle response, out_ready=1 -> req addrs 0x0,0x4,0x8…; first out_valid 2 cycles after first request; out_pc sequence 0x0,0x4,0x8 with matching data.
- out_ready=0, DEPTH=4 -> exactly 4 requests total, then imem_req_valid=0; after out_ready=1 one pop per cycle and a new request per freed slot.
- 3-cycle response latency, redirect jal with alu_out=0x100 while 2 requests in flight -> both stale responses dropped; first out_pc=0x100.
- jalr with alu_out=0x203 -> fetch from 0x200, misalign=1 for exactly one cycle; jalr with 0x201 -> 0x200, misalign=0.
- Redirect in the same cycle as a response and a pop -> buffer empty next cycle; drop_cnt correct; no stale instruction ever reaches out.
- rst asserted with 3 buffered entries -> out_valid=0 immediately; after release fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN: 2 redirects -> perf_redirects=2.
